// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and a
// two-entry skid buffer; o_up_ready is registered so i_dn_ready never reaches it.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | no beat held; o_dn_valid=0, o_up_ready=1
// ST_ONE   | beat in main; o_dn_valid=1, o_up_ready=1
// ST_FULL  | beats in main and skid; o_dn_valid=1, o_up_ready=0
module pipe_stage_skid #(
  parameter int                DATA_W            = 64,
  parameter logic [DATA_W-1:0] RESET_DATA        = '0,
  parameter bit                FLUSH_CLEARS_DATA = 1'b1,
  parameter int                STALL_CNT_W       = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_up_valid,
  output logic                   o_up_ready,
  input  logic [DATA_W-1:0]      i_up_data,
  output logic                   o_dn_valid,
  input  logic                   i_dn_ready,
  output logic [DATA_W-1:0]      o_dn_data,
  output logic [1:0]             o_occupancy,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  // Encoding equals the number of buffered beats.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      main_q, main_d;
  logic [DATA_W-1:0]      skid_q, skid_d;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   up_fire, dn_fire;

  assign o_up_ready  = (state_q != ST_FULL);
  assign o_dn_valid  = (state_q != ST_EMPTY);
  assign o_dn_data   = main_q;
  assign o_occupancy = state_q;
  assign o_stall_cnt = stall_q;

  assign up_fire = i_up_valid & o_up_ready;
  assign dn_fire = o_dn_valid & i_dn_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_DATA;
      skid_q  <= RESET_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (up_fire) begin
          state_d = ST_ONE;
          main_d  = i_up_data;
        end
      end
      ST_ONE: begin
        if (up_fire && dn_fire) begin
          main_d = i_up_data;
        end else if (up_fire) begin
          state_d = ST_FULL;
          skid_d  = i_up_data;
        end else if (dn_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (dn_fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush overrides the handshake; an accepted upstream beat is discarded.
    if (i_flush) begin
      state_d = ST_EMPTY;
      if (FLUSH_CLEARS_DATA) begin
        main_d = RESET_DATA;
        skid_d = RESET_DATA;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end
  end

  // Stall counter sees the pre-flush view and saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q <= '0;
    end else if (o_dn_valid && !i_dn_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized and directed bench for pipe_stage_skid; two instances share the
// stimulus, one clearing data on flush and one holding it.
module tb_pipe_stage_skid;

  localparam logic [63:0] RST_VAL = 64'hDEAD_BEEF_0000_0001;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_up_valid = 1'b0;
  logic [63:0] i_up_data = '0;
  logic        i_dn_ready = 1'b0;

  logic        up_ready1, dn_valid1, up_ready0, dn_valid0;
  logic [63:0] dn_data1, dn_data0;
  logic [1:0]  occ1, occ0;
  logic [3:0]  stall1;
  logic [15:0] stall0;

  always #5 i_clk = ~i_clk;

  pipe_stage_skid #(.DATA_W(64), .RESET_DATA(RST_VAL), .FLUSH_CLEARS_DATA(1'b1),
                    .STALL_CNT_W(4)) dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_up_valid(i_up_valid), .o_up_ready(up_ready1), .i_up_data(i_up_data),
    .o_dn_valid(dn_valid1), .i_dn_ready(i_dn_ready), .o_dn_data(dn_data1),
    .o_occupancy(occ1), .o_stall_cnt(stall1));

  pipe_stage_skid #(.DATA_W(64), .RESET_DATA(RST_VAL), .FLUSH_CLEARS_DATA(1'b0),
                    .STALL_CNT_W(16)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_up_valid(i_up_valid), .o_up_ready(up_ready0), .i_up_data(i_up_data),
    .o_dn_valid(dn_valid0), .i_dn_ready(i_dn_ready), .o_dn_data(dn_data0),
    .o_occupancy(occ0), .o_stall_cnt(stall0));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: FIFO of accepted beats plus the last value seen at the head.
  logic [63:0] mq[$];
  logic [63:0] last1 = RST_VAL;
  logic [63:0] last0 = RST_VAL;
  int          st1 = 0;
  int          st0 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return mq.size() < 2;
  endfunction

  task automatic model_step();
    bit dv, uf, df;
    dv = (mq.size() != 0);
    uf = i_up_valid && model_ready();
    df = dv && i_dn_ready;
    if (i_rst) begin
      mq.delete();
      last1 = RST_VAL;
      last0 = RST_VAL;
      st1 = 0;
      st0 = 0;
      return;
    end
    if (dv && !i_dn_ready) begin
      if (st1 < 15) st1++;
      if (st0 < 65535) st0++;
    end
    if (i_flush) begin
      mq.delete();
      last1 = RST_VAL;
      return;
    end
    if (df) void'(mq.pop_front());
    if (uf) mq.push_back(i_up_data);
    if (mq.size() != 0) begin
      last1 = mq[0];
      last0 = mq[0];
    end
  endtask

  task automatic check_all();
    logic [63:0] occ_exp;
    occ_exp = 64'(mq.size());
    chk("dn_valid1", 64'(dn_valid1), 64'(mq.size() != 0));
    chk("dn_valid0", 64'(dn_valid0), 64'(mq.size() != 0));
    chk("up_ready1", 64'(up_ready1), 64'(mq.size() < 2));
    chk("up_ready0", 64'(up_ready0), 64'(mq.size() < 2));
    chk("occ1", 64'(occ1), occ_exp);
    chk("occ0", 64'(occ0), occ_exp);
    chk("data1", dn_data1, last1);
    chk("data0", dn_data0, last0);
    chk("stall1", 64'(stall1), 64'(st1));
    chk("stall0", 64'(stall0), 64'(st0));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_step();
    @(negedge i_clk);
    check_all();
  endtask

  task automatic drive(input bit rst, input bit fl, input bit uv, input logic [63:0] d,
                       input bit dr);
    i_rst = rst; i_flush = fl; i_up_valid = uv; i_up_data = d; i_dn_ready = dr;
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0);
  endtask

  // Leaves the stage FULL with 0xA in main and 0xB in skid.
  task automatic load_ab();
    drive(0, 0, 1, 64'hA, 1);
    step();
    drive(0, 0, 1, 64'hB, 0);
    step();
  endtask

  initial begin
    int accepted;
    int cyc;

    do_reset();
    chk("rst_occ", 64'(occ1), 64'd0);
    chk("rst_ready", 64'(up_ready1), 64'd1);
    chk("rst_data", dn_data1, RST_VAL);
    chk("rst_stall", 64'(stall0), 64'd0);

    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 64'(k), 1);
      step();
      chk("stream_data", dn_data1, 64'(k));
      chk("stream_occ", 64'(occ1), 64'd1);
    end
    drive(0, 0, 0, 0, 1);
    step();
    chk("stream_stall", 64'(stall0), 64'd0);

    do_reset();
    load_ab();
    chk("skid_ready", 64'(up_ready1), 64'd0);
    chk("skid_data", dn_data1, 64'hA);
    chk("skid_occ", 64'(occ1), 64'd2);
    drive(0, 0, 0, 0, 1);
    step();
    chk("skid_second", dn_data1, 64'hB);
    step();
    chk("skid_stall", 64'(stall0), 64'd1);
    chk("skid_empty", 64'(dn_valid1), 64'd0);

    do_reset();
    load_ab();
    drive(0, 1, 1, 64'hC, 0);
    step();
    chk("flush_valid", 64'(dn_valid1), 64'd0);
    chk("flush_data1", dn_data1, RST_VAL);
    chk("flush_data0", dn_data0, 64'hA);
    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step();

    do_reset();
    drive(0, 0, 1, 64'h55, 1);
    step();
    drive(0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) step();
    chk("sat_stall", 64'(stall1), 64'd15);
    drive(0, 1, 0, 0, 0);
    step();
    chk("sat_flush", 64'(stall1), 64'd15);
    drive(1, 0, 0, 0, 0);
    step();
    chk("sat_reset", 64'(stall1), 64'd0);

    drive(0, 0, 0, 0, 0);
    step();
    load_ab();
    drive(1, 1, 1, 64'hC, 0);
    step();
    chk("rmid_occ", 64'(occ1), 64'd0);
    chk("rmid_ready", 64'(up_ready0), 64'd1);
    chk("rmid_data0", dn_data0, RST_VAL);
    chk("rmid_stall", 64'(stall1), 64'd0);
    drive(0, 0, 0, 0, 0);

    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      drive(0, ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70),
            {$urandom, $urandom}, ($urandom_range(0, 99) < 60));
      if (i_up_valid && model_ready() && !i_flush) accepted++;
      step();
      cyc++;
    end
    chk("rand_budget", 64'(accepted >= 1000), 64'd1);

    drive(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step();
    chk("drain_occ", 64'(occ0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
